fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_skid.sv | 42 ++++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, the NOP instruction word,
// the instruction-memory address width and the skid-entry layout.
package fetch_pkg;

    localparam logic [1:0] REQ   = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [31:0] NOP_IR  = 32'h0000_0000;
    localparam int          IMEM_AW = 12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    // Sequential PC advance; wrap past 32'hFFFFFFFF is intended.
    function automatic logic [31:0] pc_step(input logic [31:0] pc, input logic [31:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction fetched while the F/D latch is
// stalled. Flush has priority over load, load over drain.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         valid
);

    fetch_entry_t entry_r;
    logic         valid_r;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            entry_r <= '{pc: 32'h0, ir: NOP_IR};
            valid_r <= 1'b0;
        end else if (flush) begin
            entry_r <= '{pc: 32'h0, ir: NOP_IR};
            valid_r <= 1'b0;
        end else if (load) begin
            entry_r <= din;
            valid_r <= 1'b1;
        end else if (drain) begin
            entry_r <= entry_r;
            valid_r <= 1'b0;
        end else begin
            entry_r <= entry_r;
            valid_r <= valid_r;
        end
    end

    assign dout  = entry_r;
    assign valid = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word requests to instruction memory and feeds
// the F/D latch, with a one-entry skid for stalls and redirect flushing.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cnt output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd1
)(
    input  logic               clk,
    input  logic               clr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic [31:0]        fetch_pc,
    output logic [31:0]        fetch_ir,
    output logic               fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    logic [1:0]   state_r, state_s;
    logic [31:0]  pc_r, pc_s, pc_inc_s;
    logic [31:0]  req_addr_r, req_addr_s;
    logic [31:0]  fetch_pc_r, fetch_pc_s;
    logic [31:0]  fetch_ir_r, fetch_ir_s;
    logic         fetch_valid_r, fetch_valid_s;
    logic         imem_req_r;
    logic         skid_load_s, skid_drain_s, skid_flush_s, skid_valid_s;
    fetch_entry_t skid_din_s, skid_dout_s;

    assign pc_inc_s   = pc_step(pc_r, PC_INC);
    assign skid_din_s = '{pc: req_addr_r, ir: imem_data};

    fetch_skid u_skid (
        .clk   (clk),
        .clr   (clr),
        .load  (skid_load_s),
        .drain (skid_drain_s),
        .flush (skid_flush_s),
        .din   (skid_din_s),
        .dout  (skid_dout_s),
        .valid (skid_valid_s)
    );

    // Next-state and datapath decisions; redirect overrides every state.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        req_addr_s    = req_addr_r;
        fetch_pc_s    = fetch_pc_r;
        fetch_ir_s    = fetch_ir_r;
        fetch_valid_s = fetch_valid_r;
        skid_load_s   = 1'b0;
        skid_drain_s  = 1'b0;
        skid_flush_s  = 1'b0;
        if (redirect) begin
            pc_s          = redirect_pc;
            fetch_valid_s = 1'b0;
            fetch_ir_s    = NOP_IR;
            skid_flush_s  = 1'b1;
            // An unacknowledged request must complete on its original address.
            if ((state_r != HOLD) && !imem_ack) begin
                state_s = FLUSH;
            end else begin
                state_s    = REQ;
                req_addr_s = redirect_pc;
            end
        end else begin
            case (state_r)
                REQ: begin
                    if (imem_ack) begin
                        pc_s       = pc_inc_s;
                        req_addr_s = pc_inc_s;
                        if (!stall || !fetch_valid_r) begin
                            fetch_pc_s    = req_addr_r;
                            fetch_ir_s    = imem_data;
                            fetch_valid_s = 1'b1;
                        end else begin
                            skid_load_s = 1'b1;
                            state_s     = HOLD;
                        end
                    end else if (!stall) begin
                        fetch_valid_s = 1'b0;
                    end else begin
                        fetch_valid_s = fetch_valid_r;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fetch_pc_s    = skid_dout_s.pc;
                        fetch_ir_s    = skid_dout_s.ir;
                        fetch_valid_s = skid_valid_s;
                        skid_drain_s  = 1'b1;
                        state_s       = REQ;
                    end else begin
                        state_s = HOLD;
                    end
                end
                FLUSH: begin
                    if (imem_ack) begin
                        state_s    = REQ;
                        req_addr_s = pc_r;
                    end else begin
                        state_s = FLUSH;
                    end
                end
                default: begin
                    state_s       = REQ;
                    req_addr_s    = pc_r;
                    fetch_valid_s = 1'b0;
                    skid_flush_s  = 1'b1;
                end
            endcase
        end
    end

    // State, PC and F/D output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r       <= REQ;
            pc_r          <= RESET_PC;
            req_addr_r    <= RESET_PC;
            fetch_pc_r    <= 32'h0;
            fetch_ir_r    <= NOP_IR;
            fetch_valid_r <= 1'b0;
            imem_req_r    <= 1'b1;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            req_addr_r    <= req_addr_s;
            fetch_pc_r    <= fetch_pc_s;
            fetch_ir_r    <= fetch_ir_s;
            fetch_valid_r <= fetch_valid_s;
            imem_req_r    <= (state_s != HOLD);
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = req_addr_r[IMEM_AW-1:0];
    assign fetch_pc    = fetch_pc_r;
    assign fetch_ir    = fetch_ir_r;
    assign fetch_valid = fetch_valid_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where a valid instruction sits stalled.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stall_cnt_r <= 32'h0;
        end else if (redirect) begin
            stall_cnt_r <= 32'h0;
        end else if (stall && fetch_valid_r && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-order reference of the delivered instruction stream.
module tb_fetch_unit;

    logic        clk, clr, stall, redirect, imem_ack, imem_req, fetch_valid;
    logic [31:0] redirect_pc, imem_data, fetch_pc, fetch_ir;
    logic [11:0] imem_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int low_cycles;
    int consumed;
    logic [31:0] exp_pc;
    logic        prev_pend, prev_redir;
    logic [11:0] prev_addr;
    logic        s_v, r_v, a_v;
    logic [31:0] rpc_v;

    fetch_unit dut (
        .clk         (clk),
        .clr         (clr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .fetch_pc    (fetch_pc),
        .fetch_ir    (fetch_ir),
        .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {4'hC, a, 4'h3, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ir);
        check({tag, "_valid"}, {31'h0, fetch_valid}, {31'h0, v});
        check({tag, "_pc"}, fetch_pc, pc);
        check({tag, "_ir"}, fetch_ir, ir);
    endtask

    task automatic check_req(input string tag, input logic rq, input logic [11:0] addr);
        check(tag, {19'h0, imem_req, imem_addr}, {19'h0, rq, addr});
    endtask

    // Drive one cycle of inputs (called at a negedge), then wait for the next negedge.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rpc,
                       input logic a, input logic [31:0] d);
        stall = s; redirect = r; redirect_pc = rpc; imem_ack = a; imem_data = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        clr = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; imem_data = 32'h0;
        #1;
        check_out("rst", 1'b0, 32'h0, 32'h0);
        check_req("rst_req", 1'b1, 12'h000);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_data = 32'h0;

        // Back-to-back fetch after reset
        do_reset();
        check_req("r29_first", 1'b1, 12'h000);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA);
        check_out("r29_a", 1'b1, 32'h0, 32'hA);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hB);
        check_out("r29_b", 1'b1, 32'h1, 32'hB);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hC);
        check_out("r29_c", 1'b1, 32'h2, 32'hC);
        check_req("r29_next", 1'b1, 12'h003);

        // Stall for three cycles with ack: one skid capture, two idle request cycles
        do_reset();
        low_cycles = 0;
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hA);
        if (!imem_req) low_cycles++;
        check_out("r30_0", 1'b1, 32'h0, 32'hA);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hB);
        if (!imem_req) low_cycles++;
        check_out("r30_hold1", 1'b1, 32'h0, 32'hA);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        if (!imem_req) low_cycles++;
        check_out("r30_hold2", 1'b1, 32'h0, 32'hA);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if (!imem_req) low_cycles++;
        check_out("r30_pc1", 1'b1, 32'h1, 32'hB);
        check_req("r30_req", 1'b1, 12'h002);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hC);
        if (!imem_req) low_cycles++;
        check_out("r30_pc2", 1'b1, 32'h2, 32'hC);
        check("r30_req_low", low_cycles, 32'd2);

        // Redirect with an outstanding request: late data is discarded
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, mem_word(i[11:0]));
        check_req("r31_at5", 1'b1, 12'h005);
        cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check_req("r31_flush_addr", 1'b1, 12'h005);
        check("r31_flush_valid", {31'h0, fetch_valid}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_req("r31_flush_wait", 1'b1, 12'h005);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD);
        check_out("r31_discard", 1'b0, 32'h4, 32'h0);
        check_req("r31_newaddr", 1'b1, 12'h040);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234);
        check_out("r31_first", 1'b1, 32'h40, 32'h1234);

        // Redirect coincident with ack and stall
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA);
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 32'hB);
        check("r32_valid", {31'h0, fetch_valid}, 32'h0);
        check("r32_ir", fetch_ir, 32'h0);
        check_req("r32_req", 1'b1, 12'h080);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("r32_still_empty", {31'h0, fetch_valid}, 32'h0);
        check_req("r32_still_req", 1'b1, 12'h080);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h99);
        check_out("r32_first", 1'b1, 32'h80, 32'h99);

        // PC wrap at 32 bits
        do_reset();
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h5);
        check_req("r33_top", 1'b1, 12'hFFF);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h77);
        check_out("r33_last", 1'b1, 32'hFFFF_FFFF, 32'h77);
        check_req("r33_wrap_addr", 1'b1, 12'h000);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h78);
        check_out("r33_wrap", 1'b1, 32'h0, 32'h78);

`ifdef FETCH_PERF_CNT_EN
        // Stall counter
        do_reset();
        check("r34_rst", stall_cnt, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("r34_seven", stall_cnt, 32'd7);
        cyc(1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
        check("r34_clear", stall_cnt, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("r34_no_valid", stall_cnt, 32'h0);
`endif

        // Randomized run against the program-order stream model
        do_reset();
        exp_pc = 32'h0; prev_pend = 1'b0; prev_redir = 1'b0; prev_addr = 12'h0; consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (prev_pend) check_req("rnd_req_stable", 1'b1, prev_addr);
            if (prev_redir) check("rnd_redir_valid", {31'h0, fetch_valid}, 32'h0);
            if (fetch_valid) check("rnd_ir", fetch_ir, mem_word(fetch_pc[11:0]));
            s_v   = ($urandom_range(0, 99) < 30);
            r_v   = ($urandom_range(0, 99) < 5);
            rpc_v = r_v ? (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom) : 32'h0;
            a_v   = imem_req && ($urandom_range(0, 99) < 60);
            if (fetch_valid && !s_v && !r_v) begin
                check("rnd_order", fetch_pc, exp_pc);
                exp_pc = exp_pc + 32'd1;
                consumed++;
            end
            if (r_v) exp_pc = rpc_v;
            prev_pend  = imem_req && !a_v;
            prev_addr  = imem_addr;
            prev_redir = r_v;
            cyc(s_v, r_v, rpc_v, a_v, mem_word(imem_addr));
        end
        check("rnd_progress", {31'h0, (consumed > 100)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
